// File: rtl/qosc_ctrl.sv
// qosc_ctrl -- quadrature oscillator sequencing controller.
//
// A 16-bit serial configuration frame (sclk/sdi/cs_n, asynchronous to clk)
// loads shadow registers. A start command copies every shadow register into
// the active output registers, holds the oscillator preload (load) for
// LOAD_CYCLES clocks and then issues advance strobes (step) until stop.
//
// Build option: define QOSC_CTRL_PRESCALE_EN to add the prescale register
// (address 5) and the step prescale counter. Without it, step fires on every
// RUN cycle and address 5 is ignored.
//
// Ports
//   clk                   system clock, all state on rising edge
//   rst_n                 asynchronous active-low reset
//   cfg_sclk/sdi/cs_n     serial config pins (asynchronous)
//   start, stop           one-cycle command strobes (stop wins)
//   re_coeff, im_coeff, power, accu_re_init, accu_im_init
//                         active oscillator settings (8 bits each)
//   load                  oscillator preload, high for LOAD_CYCLES cycles
//   step                  oscillator advance strobe, RUN only
//   busy                  state != IDLE
//   state                 IDLE=00, LOAD=01, RUN=10
//
// FSM states
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_LOAD | load asserted, counting down the preload pulse
//   ST_RUN  | issuing step strobes at the prescaled rate

module qosc_ctrl #(
  parameter int unsigned LOAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_sclk,
  input  logic       cfg_sdi,
  input  logic       cfg_cs_n,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] re_coeff,
  output logic [7:0] im_coeff,
  output logic [7:0] power,
  output logic [7:0] accu_re_init,
  output logic [7:0] accu_im_init,
  output logic       load,
  output logic       step,
  output logic       busy,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

  localparam logic [7:0] RST_RE    = 8'h7D;
  localparam logic [7:0] RST_IM    = 8'h1B;
  localparam logic [7:0] RST_POWER = 8'h40;
  localparam logic [7:0] RST_ACCRE = 8'h20;
  localparam logic [7:0] RST_ACCIM = 8'h00;

  // ---------------------------------------------------------------------
  // Pin synchronizers and edge detection (synchronized domain only)
  // ---------------------------------------------------------------------
  logic [1:0] sclk_sync_q, sdi_sync_q, csn_sync_q;
  logic       sclk_prev_q, csn_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      sdi_sync_q  <= 2'b00;
      csn_sync_q  <= 2'b11;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], cfg_sclk};
      sdi_sync_q  <= {sdi_sync_q[0], cfg_sdi};
      csn_sync_q  <= {csn_sync_q[0], cfg_cs_n};
      sclk_prev_q <= sclk_sync_q[1];
      csn_prev_q  <= csn_sync_q[1];
    end
  end

  logic sclk_rise, csn_fall, csn_rise;
  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign csn_fall  = ~csn_sync_q[1] & csn_prev_q;
  assign csn_rise  = csn_sync_q[1] & ~csn_prev_q;

  // ---------------------------------------------------------------------
  // Frame shifter. The bit counter saturates at 17 so any over-length
  // frame stays distinguishable from a legal 16-bit one.
  // ---------------------------------------------------------------------
  logic [15:0] shift_q;
  logic [4:0]  bit_cnt_q;
  logic        commit_q;
  logic [2:0]  frame_addr_q;
  logic [7:0]  frame_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      commit_q     <= 1'b0;
      frame_addr_q <= '0;
      frame_data_q <= '0;
    end else begin
      if (csn_fall) begin
        bit_cnt_q <= '0;
      end else if (sclk_rise && !csn_sync_q[1]) begin
        shift_q <= {shift_q[14:0], sdi_sync_q[1]};
        if (bit_cnt_q != 5'd17) begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
      end
      commit_q <= csn_rise && (bit_cnt_q == 5'd16);
      if (csn_rise) begin
        frame_addr_q <= shift_q[15:13];
        frame_data_q <= shift_q[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shadow registers, written the cycle after the commit decision
  // ---------------------------------------------------------------------
  logic [7:0] sh_re_q, sh_im_q, sh_power_q, sh_accre_q, sh_accim_q;
`ifdef QOSC_CTRL_PRESCALE_EN
  logic [7:0] sh_presc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_re_q    <= RST_RE;
      sh_im_q    <= RST_IM;
      sh_power_q <= RST_POWER;
      sh_accre_q <= RST_ACCRE;
      sh_accim_q <= RST_ACCIM;
`ifdef QOSC_CTRL_PRESCALE_EN
      sh_presc_q <= 8'h00;
`endif
    end else if (commit_q) begin
      case (frame_addr_q)
        3'd0:    sh_re_q    <= frame_data_q;
        3'd1:    sh_im_q    <= frame_data_q;
        3'd2:    sh_power_q <= frame_data_q;
        3'd3:    sh_accre_q <= frame_data_q;
        3'd4:    sh_accim_q <= frame_data_q;
`ifdef QOSC_CTRL_PRESCALE_EN
        3'd5:    sh_presc_q <= frame_data_q;
`endif
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] load_cnt_q, load_cnt_d;
  logic       copy_en;
  logic       presc_hit;

`ifdef QOSC_CTRL_PRESCALE_EN
  logic [7:0] act_presc_q;
  logic [7:0] presc_cnt_q, presc_cnt_d;
  assign presc_hit = (presc_cnt_q == act_presc_q);
`else
  assign presc_hit = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
`ifdef QOSC_CTRL_PRESCALE_EN
    presc_cnt_d = presc_cnt_q;
`endif
    copy_en = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_LOAD;
          load_cnt_d = LOAD_LAST;
          copy_en    = 1'b1;
        end
      end
      ST_LOAD: begin
        load = 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (load_cnt_q == 4'd0) begin
          state_d = ST_RUN;
`ifdef QOSC_CTRL_PRESCALE_EN
          presc_cnt_d = 8'd0;
`endif
        end else begin
          load_cnt_d = load_cnt_q - 4'd1;
        end
      end
      ST_RUN: begin
        step = presc_hit;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d    = ST_LOAD;
          load_cnt_d = LOAD_LAST;
          copy_en    = 1'b1;
        end else begin
`ifdef QOSC_CTRL_PRESCALE_EN
          presc_cnt_d = presc_hit ? 8'd0 : presc_cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
`ifdef QOSC_CTRL_PRESCALE_EN
      presc_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
`ifdef QOSC_CTRL_PRESCALE_EN
      presc_cnt_q <= presc_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Active registers: only refreshed on LOAD entry
  // ---------------------------------------------------------------------
  logic [7:0] act_re_q, act_im_q, act_power_q, act_accre_q, act_accim_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_re_q    <= RST_RE;
      act_im_q    <= RST_IM;
      act_power_q <= RST_POWER;
      act_accre_q <= RST_ACCRE;
      act_accim_q <= RST_ACCIM;
`ifdef QOSC_CTRL_PRESCALE_EN
      act_presc_q <= 8'h00;
`endif
    end else if (copy_en) begin
      act_re_q    <= sh_re_q;
      act_im_q    <= sh_im_q;
      act_power_q <= sh_power_q;
      act_accre_q <= sh_accre_q;
      act_accim_q <= sh_accim_q;
`ifdef QOSC_CTRL_PRESCALE_EN
      act_presc_q <= sh_presc_q;
`endif
    end
  end

  assign re_coeff     = act_re_q;
  assign im_coeff     = act_im_q;
  assign power        = act_power_q;
  assign accu_re_init = act_accre_q;
  assign accu_im_init = act_accim_q;
  assign busy         = (state_q != ST_IDLE);
  assign state        = state_q;

endmodule

// File: tb/tb_qosc_ctrl.sv
// Self-checking bench for qosc_ctrl (default LOAD_CYCLES = 4).
// Expected output vectors are pushed to a scoreboard queue when a cycle's
// stimulus is applied and popped/compared once the DUT has produced it.
// Honours QOSC_CTRL_PRESCALE_EN when the same macro is defined for the build.

module tb_qosc_ctrl;

  localparam int LC = 4;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_sclk = 1'b0;
  logic       cfg_sdi = 1'b0;
  logic       cfg_cs_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] re_coeff, im_coeff, power, accu_re_init, accu_im_init;
  logic       load, step, busy;
  logic [1:0] state;

  qosc_ctrl #(.LOAD_CYCLES(LC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_sclk(cfg_sclk), .cfg_sdi(cfg_sdi), .cfg_cs_n(cfg_cs_n),
    .start(start), .stop(stop),
    .re_coeff(re_coeff), .im_coeff(im_coeff), .power(power),
    .accu_re_init(accu_re_init), .accu_im_init(accu_im_init),
    .load(load), .step(step), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [44:0] exp_q[$];
  string       tag_q[$];

  // bench model of shadow and active settings
  logic [7:0] s_re, s_im, s_pw, s_ar, s_ai, s_ps;
  logic [7:0] a_re, a_im, a_pw, a_ar, a_ai, a_ps;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  task automatic model_reset();
    s_re = 8'h7D; s_im = 8'h1B; s_pw = 8'h40; s_ar = 8'h20; s_ai = 8'h00; s_ps = 8'h00;
    a_re = s_re;  a_im = s_im;  a_pw = s_pw;  a_ar = s_ar;  a_ai = s_ai;  a_ps = s_ps;
  endtask

  task automatic model_copy();
    a_re = s_re; a_im = s_im; a_pw = s_pw; a_ar = s_ar; a_ai = s_ai; a_ps = s_ps;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [1:0] st, input logic ld, input logic stp);
    exp_q.push_back({st, ld, stp, (st != S_IDLE), a_re, a_im, a_pw, a_ar, a_ai});
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    logic [44:0] obs;
    logic [44:0] e;
    string t;
    obs = {state, load, step, busy, re_coeff, im_coeff, power, accu_re_init, accu_im_init};
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_empty: got %h expected nothing queued", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 64'(obs), 64'(e));
    end
  endtask

  // one clock with the given command strobes; the sampled cycle is checked
  task automatic cyc(input logic s, input logic p, input string tag,
                     input logic [1:0] st, input logic ld, input logic stp);
    start = s;
    stop  = p;
    push_exp(tag, st, ld, stp);
    tick();
    start = 1'b0;
    stop  = 1'b0;
    pop_cmp();
  endtask

  task automatic do_load(input string tag);
    model_copy();
    cyc(1'b1, 1'b0, tag, S_LOAD, 1'b1, 1'b0);
    for (int i = 1; i < LC; i++) cyc(1'b0, 1'b0, tag, S_LOAD, 1'b1, 1'b0);
  endtask

  task automatic do_run(input string tag, input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, tag, S_RUN, 1'b0, ((i % (int'(a_ps) + 1)) == int'(a_ps)));
  endtask

  task automatic do_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, tag, S_IDLE, 1'b0, 1'b0);
  endtask

  task automatic frame_begin();
    cfg_cs_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_bits(input logic [16:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_sdi = bits[i];
      repeat (2) tick();
      cfg_sclk = 1'b1;
      repeat (3) tick();
      cfg_sclk = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic frame_end();
    cfg_cs_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic send_frame(input logic [16:0] bits, input int n);
    frame_begin();
    frame_bits(bits, n);
    frame_end();
    if (n == 16) begin
      case (bits[15:13])
        3'd0: s_re = bits[7:0];
        3'd1: s_im = bits[7:0];
        3'd2: s_pw = bits[7:0];
        3'd3: s_ar = bits[7:0];
        3'd4: s_ai = bits[7:0];
`ifdef QOSC_CTRL_PRESCALE_EN
        3'd5: s_ps = bits[7:0];
`endif
        default: ;
      endcase
    end
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    cyc(1'b0, 1'b0, "rst_hold", S_IDLE, 1'b0, 1'b0);
    rst_n = 1'b1;
    do_idle("rst_release", 1);

    // default settings through a full preload and run
    do_load("boot_load");
    do_run("boot_run", 4);
    cyc(1'b0, 1'b1, "boot_stop", S_IDLE, 1'b0, 1'b0);

    // re_coeff frame only reaches the outputs on LOAD entry
    send_frame(17'h00155, 16);
    do_idle("re_hold_idle", 2);
    do_load("re_load");
    do_run("re_run", 2);
    cyc(1'b0, 1'b1, "re_stop", S_IDLE, 1'b0, 1'b0);

    // prescale 3: every 4th RUN cycle (every cycle without the feature)
    send_frame(17'h0A003, 16);
    do_load("ps_load");
    do_run("ps_run", 9);
    cyc(1'b0, 1'b1, "ps_stop", S_IDLE, 1'b0, 1'b0);

    // short and long frames are dropped, a legal one afterwards lands
    send_frame(17'h00066, 15);
    send_frame(17'h04044, 17);
    do_idle("bad_frame_idle", 1);
    do_load("bad_frame_load");
    cyc(1'b0, 1'b1, "bad_frame_stop", S_IDLE, 1'b0, 1'b0);
    send_frame(17'h04022, 16);
    do_load("power_load");

    // frame in RUN touches shadow only; restart from RUN picks it up
    send_frame(17'h02011, 16);
    chk("run_im_hold", 64'(im_coeff), 64'(a_im));
    chk("run_state_hold", 64'(state), 64'(S_RUN));
    do_load("restart_load");
    do_run("restart_run", 4);
    cyc(1'b0, 1'b1, "restart_stop", S_IDLE, 1'b0, 1'b0);

    // stop beats start; stop in second LOAD cycle aborts the pulse
    cyc(1'b1, 1'b1, "start_stop_idle", S_IDLE, 1'b0, 1'b0);
    do_idle("start_stop_after", 1);
    model_copy();
    cyc(1'b1, 1'b0, "abort_load1", S_LOAD, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, "abort_load2", S_LOAD, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, "abort_idle", S_IDLE, 1'b0, 1'b0);
    do_idle("abort_after", 3);

    // asynchronous reset in the middle of LOAD
    model_copy();
    cyc(1'b1, 1'b0, "rl_load", S_LOAD, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rl_async_state", 64'(state), 64'(S_IDLE));
    chk("rl_async_load", 64'(load), 64'(1'b0));
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    do_idle("rl_idle", 2);

    // reset in the middle of a frame: the two halves never form a frame
    frame_begin();
    frame_bits(17'h00001, 8);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    frame_bits(17'h000AA, 8);
    frame_end();
    do_idle("rf_idle", 1);
    do_load("rf_load");
    do_run("rf_run", 2);
    cyc(1'b0, 1'b1, "rf_stop", S_IDLE, 1'b0, 1'b0);

    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
